// File: rtl/seg_argmax.sv
// Per-pixel argmax over a signed score vector via a registered comparator tree, plus a
// per-frame class histogram with snapshot readback. Optional background class: SEG_ARGMAX_BG_THRESH_EN.
module seg_argmax #(
  parameter int HEIGHT    = 480,
  parameter int WIDTH     = 640,
  parameter int W_HEIGHT  = 525,
  parameter int W_WIDTH   = 800,
  parameter int UNITS     = 12,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  parameter logic signed [INT_BITW+FRAC_BITW-1:0] BG_THRESH = {(INT_BITW+FRAC_BITW){1'b0}},
  localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
  localparam int V_BITW     = $clog2(W_HEIGHT),
  localparam int H_BITW     = $clog2(W_WIDTH),
  localparam int CLS_BITW   = $clog2(UNITS + 1),
  localparam int CNT_BITW   = $clog2(HEIGHT * WIDTH + 1),
  localparam int LAT        = 1 + $clog2(UNITS)
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           in_enable,
  input  logic [0:FIXED_BITW*UNITS-1]    in_y,
  input  logic [V_BITW-1:0]              in_vcnt,
  input  logic [H_BITW-1:0]              in_hcnt,
  output logic                           out_enable,
  output logic [CLS_BITW-1:0]            out_label,
  output logic [FIXED_BITW-1:0]          out_score,
  output logic [V_BITW-1:0]              out_vcnt,
  output logic [H_BITW-1:0]              out_hcnt,
  input  logic [CLS_BITW-1:0]            hist_sel,
  output logic [CNT_BITW-1:0]            hist_count,
  output logic                           hist_valid
);

  localparam int LVLS = LAT - 1;

`ifdef SEG_ARGMAX_BG_THRESH_EN
  localparam logic BG_EN = 1'b1;
  localparam int   NBINS = UNITS + 1;
`else
  localparam logic BG_EN = 1'b0;
  localparam int   NBINS = UNITS;
`endif

  // Level 0 holds the registered inputs; level l holds the winners after l comparisons.
  logic        [CLS_BITW-1:0]   idx_r   [0:LVLS][0:UNITS-1];
  logic signed [FIXED_BITW-1:0] score_r [0:LVLS][0:UNITS-1];
  logic        [CLS_BITW-1:0]   idx_s   [1:LVLS][0:UNITS-1];
  logic signed [FIXED_BITW-1:0] score_s [1:LVLS][0:UNITS-1];
  logic                         en_r    [0:LVLS];
  logic        [V_BITW-1:0]     vcnt_r  [0:LVLS];
  logic        [H_BITW-1:0]     hcnt_r  [0:LVLS];
  logic                         bg_s;

  logic [CNT_BITW-1:0] cnt_r  [0:NBINS-1];
  logic [CNT_BITW-1:0] cnt_s  [0:NBINS-1];
  logic [CNT_BITW-1:0] snap_r [0:NBINS-1];
  logic                in_frame_r;
  logic                hist_valid_r;
  logic                is_start_s;
  logic                is_end_s;
  logic                close_s;

  function automatic int lvl_cnt(input int lvl);
    int n;
    n = UNITS;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int clamp_u(input int i);
    return (i < UNITS) ? i : UNITS - 1;
  endfunction

  // Pairwise compare per level; the left candidate always carries the lower index, so it keeps ties.
  always_comb begin
    for (int l = 1; l <= LVLS; l++) begin
      for (int j = 0; j < UNITS; j++) begin
        idx_s[l][j]   = '0;
        score_s[l][j] = '0;
        if (2 * j + 1 < lvl_cnt(l - 1)) begin
          if (score_r[l-1][clamp_u(2*j+1)] > score_r[l-1][clamp_u(2*j)]) begin
            idx_s[l][j]   = idx_r[l-1][clamp_u(2*j+1)];
            score_s[l][j] = score_r[l-1][clamp_u(2*j+1)];
          end else begin
            idx_s[l][j]   = idx_r[l-1][clamp_u(2*j)];
            score_s[l][j] = score_r[l-1][clamp_u(2*j)];
          end
        end else if (2 * j < lvl_cnt(l - 1)) begin
          idx_s[l][j]   = idx_r[l-1][clamp_u(2*j)];
          score_s[l][j] = score_r[l-1][clamp_u(2*j)];
        end else begin
          idx_s[l][j]   = '0;
          score_s[l][j] = '0;
        end
      end
    end
  end

  assign bg_s = BG_EN && (score_s[LVLS][0] < BG_THRESH);

  // Tree and sideband registers; everything advances every cycle regardless of enable.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int l = 0; l <= LVLS; l++) begin
        for (int j = 0; j < UNITS; j++) begin
          idx_r[l][j]   <= '0;
          score_r[l][j] <= '0;
        end
        en_r[l]   <= 1'b0;
        vcnt_r[l] <= '0;
        hcnt_r[l] <= '0;
      end
    end else begin
      for (int j = 0; j < UNITS; j++) begin
        idx_r[0][j]   <= CLS_BITW'(j);
        score_r[0][j] <= in_y[j*FIXED_BITW +: FIXED_BITW];
      end
      for (int l = 1; l <= LVLS; l++) begin
        for (int j = 0; j < UNITS; j++) begin
          idx_r[l][j]   <= idx_s[l][j];
          score_r[l][j] <= score_s[l][j];
        end
        en_r[l]   <= en_r[l-1];
        vcnt_r[l] <= vcnt_r[l-1];
        hcnt_r[l] <= hcnt_r[l-1];
      end
      idx_r[LVLS][0] <= bg_s ? CLS_BITW'(UNITS) : idx_s[LVLS][0];
      en_r[0]   <= in_enable;
      vcnt_r[0] <= in_vcnt;
      hcnt_r[0] <= in_hcnt;
    end
  end

  assign out_enable = en_r[LVLS];
  assign out_label  = idx_r[LVLS][0];
  assign out_score  = score_r[LVLS][0];
  assign out_vcnt   = vcnt_r[LVLS];
  assign out_hcnt   = hcnt_r[LVLS];
  assign hist_valid = hist_valid_r;

  assign is_start_s = out_enable && (out_vcnt == '0) && (out_hcnt == '0);
  assign is_end_s   = out_enable && (out_vcnt == V_BITW'(HEIGHT - 1)) && (out_hcnt == H_BITW'(WIDTH - 1));
  assign close_s    = is_end_s && (is_start_s || in_frame_r);

  // Next bin counts: a frame start wipes the partial frame, otherwise saturating increment.
  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      cnt_s[b] = cnt_r[b];
      if (is_start_s) begin
        cnt_s[b] = (out_label == CLS_BITW'(b)) ? CNT_BITW'(1'b1) : '0;
      end else if (out_enable && in_frame_r && (out_label == CLS_BITW'(b)) && (cnt_r[b] != '1)) begin
        cnt_s[b] = cnt_r[b] + CNT_BITW'(1'b1);
      end else begin
        cnt_s[b] = cnt_r[b];
      end
    end
  end

  // Live counters, frame tracking, and snapshot capture including the closing pixel.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBINS; b++) begin
        cnt_r[b]  <= '0;
        snap_r[b] <= '0;
      end
      in_frame_r   <= 1'b0;
      hist_valid_r <= 1'b0;
    end else begin
      for (int b = 0; b < NBINS; b++) begin
        cnt_r[b] <= cnt_s[b];
        if (close_s) begin
          snap_r[b] <= cnt_s[b];
        end
      end
      hist_valid_r <= close_s;
      if (close_s) begin
        in_frame_r <= 1'b0;
      end else if (is_start_s) begin
        in_frame_r <= 1'b1;
      end
    end
  end

  // Snapshot readback; selections without a bin fall through to zero.
  always_comb begin
    hist_count = '0;
    for (int b = 0; b < NBINS; b++) begin
      hist_count = hist_count | (snap_r[b] & {CNT_BITW{hist_sel == CLS_BITW'(b)}});
    end
  end

endmodule
